// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop bank between two requesters.
// Each granted op drives j/k for one cycle, then acknowledges the requester.
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] mask_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] mask_b,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [1:0]       state_r;
  logic             last_grant_r;   // 1 = B was granted last
  logic             grant_r;        // 1 = current op belongs to B
  logic             grant_valid_s;
  logic             grant_b_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_mask_s;

  function automatic logic [WIDTH-1:0] encode_j(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    case (op)
      OP_SET, OP_TOGGLE: encode_j = mask;
      OP_HOLD, OP_CLEAR: encode_j = {WIDTH{1'b0}};
      default:           encode_j = {WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] encode_k(input logic [1:0] op, input logic [WIDTH-1:0] mask);
    case (op)
      OP_CLEAR, OP_TOGGLE: encode_k = mask;
      OP_HOLD, OP_SET:     encode_k = {WIDTH{1'b0}};
      default:             encode_k = {WIDTH{1'b0}};
    endcase
  endfunction

  // Arbitration: on a tie the requester that was not granted last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_b_s     = 1'b0;
    if (req_a && req_b) begin
      grant_valid_s = 1'b1;
      grant_b_s     = ~last_grant_r;
    end else if (req_a) begin
      grant_valid_s = 1'b1;
      grant_b_s     = 1'b0;
    end else if (req_b) begin
      grant_valid_s = 1'b1;
      grant_b_s     = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_b_s     = 1'b0;
    end
    sel_op_s   = grant_b_s ? op_b   : op_a;
    sel_mask_s = grant_b_s ? mask_b : mask_a;
  end

  // FSM and registered outputs; j/k are loaded at grant so they carry the latched op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      j            <= {WIDTH{1'b0}};
      k            <= {WIDTH{1'b0}};
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      busy         <= 1'b0;
      op_count     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          if (grant_valid_s) begin
            state_r      <= DRIVE;
            busy         <= 1'b1;
            grant_r      <= grant_b_s;
            last_grant_r <= grant_b_s;
            j            <= encode_j(sel_op_s, sel_mask_s);
            k            <= encode_k(sel_op_s, sel_mask_s);
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
            j       <= {WIDTH{1'b0}};
            k       <= {WIDTH{1'b0}};
          end
        end
        DRIVE: begin
          state_r  <= ACK;
          busy     <= 1'b1;
          j        <= {WIDTH{1'b0}};
          k        <= {WIDTH{1'b0}};
          ack_a    <= ~grant_r;
          ack_b    <= grant_r;
          op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ACK: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          j       <= {WIDTH{1'b0}};
          k       <= {WIDTH{1'b0}};
          ack_a   <= 1'b0;
          ack_b   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          j       <= {WIDTH{1'b0}};
          k       <= {WIDTH{1'b0}};
          ack_a   <= 1'b0;
          ack_b   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural JK bank on j/k.
module tb_jk_bank_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0;
  logic [1:0] op_a = 2'b00;
  logic [3:0] mask_a = 4'b0000;
  logic       req_b = 1'b0;
  logic [1:0] op_b = 2'b00;
  logic [3:0] mask_b = 4'b0000;
  logic [3:0] j, k;
  logic       ack_a, ack_b, busy;
  logic [7:0] op_count;
  logic [3:0] q;

  int total = 0;
  int bad = 0;

  jk_bank_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .op_a(op_a), .mask_a(mask_a),
    .req_b(req_b), .op_b(op_b), .mask_b(mask_b),
    .j(j), .k(k), .ack_a(ack_a), .ack_b(ack_b),
    .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // JK bank
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= 4'b0000;
    else       q <= (j & ~q) | (~k & q);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00; mask_a = 4'b0000; mask_b = 4'b0000;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (busy !== 1'b0 || op_count !== 8'd0 || j !== 4'b0000 || k !== 4'b0000 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
      bad++; $display("FAIL reset_state: busy=%b cnt=%0d j=%b k=%b acks=%b%b want 0", busy, op_count, j, k, ack_a, ack_b);
    end
    req_a = 1'b1; op_a = 2'b11; mask_a = 4'b1111;
    tick();
    total++; if (j !== 4'b1111 || k !== 4'b1111 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_reset_drive: j=%b k=%b busy=%b want 1111 1111 1", j, k, busy);
    end
    #1 reset = 1'b1;
    #1;
    total++; if (j !== 4'b0000 || k !== 4'b0000 || busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0 || op_count !== 8'd0) begin
      bad++; $display("FAIL async_reset: j=%b k=%b busy=%b acks=%b%b cnt=%0d want all 0", j, k, busy, ack_a, ack_b, op_count);
    end
    req_a = 1'b0;
    #1 reset = 1'b0;
    req_a = 1'b1; op_a = 2'b00; mask_a = 4'b0000;
    req_b = 1'b1; op_b = 2'b00; mask_b = 4'b0000;
    tick();
    tick();
    total++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin
      bad++; $display("FAIL first_tie_after_reset: ack_a=%b ack_b=%b want 1 0", ack_a, ack_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  task automatic test_a_only();
    apply_reset();
    req_a = 1'b1; op_a = 2'b01; mask_a = 4'b0101;
    tick();
    total++; if (j !== 4'b0101 || k !== 4'b0000 || busy !== 1'b1 || ack_a !== 1'b0) begin
      bad++; $display("FAIL a_only_drive: j=%b k=%b busy=%b ack_a=%b want 0101 0000 1 0", j, k, busy, ack_a);
    end
    tick();
    total++; if (ack_a !== 1'b1 || ack_b !== 1'b0 || j !== 4'b0000 || k !== 4'b0000 || q !== 4'b0101 || op_count !== 8'd1) begin
      bad++; $display("FAIL a_only_ack: ack=%b%b j=%b k=%b q=%b cnt=%0d want 10 0000 0000 0101 1", ack_a, ack_b, j, k, q, op_count);
    end
    req_a = 1'b0;
    tick();
    total++; if (ack_a !== 1'b0 || busy !== 1'b0 || q !== 4'b0101) begin
      bad++; $display("FAIL a_only_idle: ack_a=%b busy=%b q=%b want 0 0 0101", ack_a, busy, q);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_q [4];
    exp_q[0] = 4'b1111; exp_q[1] = 4'b1100; exp_q[2] = 4'b0011; exp_q[3] = 4'b0000;
    apply_reset();
    req_a = 1'b1; op_a = 2'b11; mask_a = 4'b1111;
    req_b = 1'b1; op_b = 2'b10; mask_b = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) begin
        total++; if (j !== 4'b1111 || k !== 4'b1111) begin
          bad++; $display("FAIL rr_drive_a[%0d]: j=%b k=%b want 1111 1111", i, j, k);
        end
      end else begin
        total++; if (j !== 4'b0000 || k !== 4'b0011) begin
          bad++; $display("FAIL rr_drive_b[%0d]: j=%b k=%b want 0000 0011", i, j, k);
        end
      end
      tick();
      total++; if (ack_a !== (i % 2 == 0) || ack_b !== (i % 2 == 1) || q !== exp_q[i]) begin
        bad++; $display("FAIL rr_ack[%0d]: ack_a=%b ack_b=%b q=%b want %b %b %b", i, ack_a, ack_b, q, (i % 2 == 0), (i % 2 == 1), exp_q[i]);
      end
      tick();
      total++; if (busy !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0) begin
        bad++; $display("FAIL rr_idle[%0d]: busy=%b acks=%b%b want 0 00", i, busy, ack_a, ack_b);
      end
    end
    total++; if (op_count !== 8'd4) begin
      bad++; $display("FAIL rr_count: got %0d want 4", op_count);
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_hold_b();
    apply_reset();
    req_a = 1'b1; op_a = 2'b01; mask_a = 4'b0110;
    tick(); tick();
    req_a = 1'b0;
    tick();
    req_b = 1'b1; op_b = 2'b00; mask_b = 4'b1111;
    tick();
    total++; if (j !== 4'b0000 || k !== 4'b0000 || busy !== 1'b1) begin
      bad++; $display("FAIL hold_drive: j=%b k=%b busy=%b want 0000 0000 1", j, k, busy);
    end
    tick();
    total++; if (ack_b !== 1'b1 || ack_a !== 1'b0 || q !== 4'b0110 || op_count !== 8'd2) begin
      bad++; $display("FAIL hold_ack: ack=%b%b q=%b cnt=%0d want 01 0110 2", ack_a, ack_b, q, op_count);
    end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    req_a = 1'b1; op_a = 2'b00; mask_a = 4'b0000;
    for (int i = 0; i < 255; i++) begin
      tick(); tick(); tick();
    end
    total++; if (op_count !== 8'd255) begin
      bad++; $display("FAIL wrap_255: got %0d want 255", op_count);
    end
    tick(); tick();
    total++; if (op_count !== 8'd0 || ack_a !== 1'b1) begin
      bad++; $display("FAIL wrap_zero: cnt=%0d ack_a=%b want 0 1", op_count, ack_a);
    end
    tick(); tick(); tick();
    total++; if (op_count !== 8'd1 || ack_a !== 1'b1) begin
      bad++; $display("FAIL wrap_one: cnt=%0d ack_a=%b want 1 1", op_count, ack_a);
    end
    req_a = 1'b0;
    tick();
  endtask

  task automatic test_latch();
    apply_reset();
    req_a = 1'b1; op_a = 2'b11; mask_a = 4'b1010;
    tick();
    op_a = 2'b01; mask_a = 4'b0001;
    #2;
    total++; if (j !== 4'b1010 || k !== 4'b1010) begin
      bad++; $display("FAIL latch_drive: j=%b k=%b want 1010 1010", j, k);
    end
    tick();
    total++; if (q !== 4'b1010 || ack_a !== 1'b1) begin
      bad++; $display("FAIL latch_result: q=%b ack_a=%b want 1010 1", q, ack_a);
    end
    req_a = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_round_robin();
    test_hold_b();
    test_wrap();
    test_latch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
